// File: rtl/dca_matrix_lsu_store_packer_pkg.sv
// rtl/dca_matrix_lsu_store_packer_pkg.sv - shared widths, instruction-info layout and row-buffer entry type
// Purpose: configuration selectors, derived bus widths, the winst_info field layout,
//          the buffered row entry and an LSA clamp helper used by the store packer.
// Ports:   none (package).
package dca_matrix_lsu_store_packer_pkg;

    localparam int LSU_PARA         = 0;
    localparam int AXI_PARA         = 32;
    localparam int MATRIX_SIZE_PARA = 4;

    localparam int MATRIX_NUM_COL       = MATRIX_SIZE_PARA;
    localparam int BW_LSU_ELEMENT       = 32;
    localparam int BW_LSU_ELEMENT_ROW   = BW_LSU_ELEMENT * MATRIX_NUM_COL;
    localparam int BW_MEMORY_ROW_BUFFER = AXI_PARA * 4;
    localparam int BW_WSTRB             = BW_MEMORY_ROW_BUFFER / 8;
    localparam int BW_TXN_INFO          = (LSU_PARA == 0) ? 8 : 12;

    // LSA encodings: 0=1b, 1=2b, 2=4b, 3=8b, 4=16b, 5=32b
    localparam logic [2:0] LSA_MAX = 3'd5;

    typedef struct packed {
        logic [MATRIX_NUM_COL-1:0] col_mask;
        logic [2:0]                addr_lsa_p3;
        logic                      is_float;
        logic                      is_signed;
        logic [7:0]                num_col_m1;
        logic [7:0]                num_row_m1;
        logic [7:0]                stride_ls3;
        logic [31:0]               addr;
        logic [3:0]                opcode;
    } winst_info_t;

    localparam int BW_RRESP_INFO = $bits(winst_info_t);

    typedef struct packed {
        logic [BW_MEMORY_ROW_BUFFER-1:0] wdata;
        logic [BW_WSTRB-1:0]             wstrb;
        logic                            last;
        logic [BW_TXN_INFO-1:0]          txn_info;
    } row_entry_t;

    function automatic logic [2:0] clamp_lsa(input logic [2:0] lsa);
        return (lsa > LSA_MAX) ? LSA_MAX : lsa;
    endfunction

endpackage

// File: rtl/dca_matrix_lsu_store_packer_if.sv
// rtl/dca_matrix_lsu_store_packer_if.sv - row-in / packed-row-out handshake bundle
// Purpose: groups the element-row input handshake and the packed-row output handshake.
// Ports (signals): winst_info, in_valid, in_ready, in_row, in_txn_info,
//                  out_valid, out_ready, out_wdata, out_wstrb, out_last, out_txn_info.
// Modports: master = row producer / packed-row consumer, slave = the packer.
interface dca_matrix_lsu_store_packer_if;

    dca_matrix_lsu_store_packer_pkg::winst_info_t                                     winst_info;
    logic                                                                             in_valid;
    logic                                                                             in_ready;
    logic [dca_matrix_lsu_store_packer_pkg::BW_LSU_ELEMENT_ROW-1:0]                   in_row;
    logic [dca_matrix_lsu_store_packer_pkg::BW_TXN_INFO-1:0]                          in_txn_info;
    logic                                                                             out_valid;
    logic                                                                             out_ready;
    logic [dca_matrix_lsu_store_packer_pkg::BW_MEMORY_ROW_BUFFER-1:0]                 out_wdata;
    logic [dca_matrix_lsu_store_packer_pkg::BW_WSTRB-1:0]                             out_wstrb;
    logic                                                                             out_last;
    logic [dca_matrix_lsu_store_packer_pkg::BW_TXN_INFO-1:0]                          out_txn_info;

    modport master (
        output winst_info, in_valid, in_row, in_txn_info, out_ready,
        input  in_ready, out_valid, out_wdata, out_wstrb, out_last, out_txn_info
    );

    modport slave (
        input  winst_info, in_valid, in_row, in_txn_info, out_ready,
        output in_ready, out_valid, out_wdata, out_wstrb, out_last, out_txn_info
    );

endinterface

// File: rtl/dca_matrix_lsu_store_packer_elem_narrow.sv
// rtl/dca_matrix_lsu_store_packer_elem_narrow.sv - per-element narrowing to 2^lsa bits
// Purpose: combinational truncate (or, with DCA_STORE_SATURATE_EN, clamp for integers)
//          of one LSU element to W=2^lsa bits; bits at or above W are zero.
// Ports:   i_elem (element), i_lsa (clamped 0..5), i_is_signed, i_is_float, o_elem (narrowed).
// Config:  DCA_STORE_SATURATE_EN selects saturation for integer elements.
module dca_lsu_store_elem_narrow
    import dca_matrix_lsu_store_packer_pkg::*;
(
    input  logic [BW_LSU_ELEMENT-1:0] i_elem,
    input  logic [2:0]                i_lsa,
    input  logic                      i_is_signed,
    input  logic                      i_is_float,
    output logic [BW_LSU_ELEMENT-1:0] o_elem
);

    // Low W bits set.
    logic [BW_LSU_ELEMENT-1:0] w_mask;
    assign w_mask = {BW_LSU_ELEMENT{1'b1}} >> (BW_LSU_ELEMENT - (1 << i_lsa));

`ifdef DCA_STORE_SATURATE_EN
    // Signed maximum 2^(W-1)-1; its complement is the signed minimum -2^(W-1).
    logic [BW_LSU_ELEMENT-1:0] w_smax;
    assign w_smax = w_mask >> 1;

    always_comb begin
        o_elem = i_elem & w_mask;
        if (!i_is_float) begin
            if (i_is_signed) begin
                if ($signed(i_elem) > $signed(w_smax)) begin
                    o_elem = w_smax;
                end else if ($signed(i_elem) < $signed(~w_smax)) begin
                    o_elem = ~w_smax & w_mask;
                end
            end else begin
                // Unsigned destination still interprets the source as signed.
                if (i_elem[BW_LSU_ELEMENT-1]) begin
                    o_elem = '0;
                end else if (i_elem > w_mask) begin
                    o_elem = w_mask;
                end
            end
        end
    end
`else
    assign o_elem = i_elem & w_mask;

    logic w_unused_flags;
    assign w_unused_flags = i_is_signed ^ i_is_float;
`endif

endmodule

// File: rtl/dca_matrix_lsu_store_packer.sv
// rtl/dca_matrix_lsu_store_packer.sv - store-side row packer with strobes, last-row tag and 2-entry output buffer
// Purpose: narrows each element of an LSU row to 2^lsa bits, packs them into a memory row,
//          builds byte strobes, tags the last row of a matrix and buffers up to two packed rows.
// Ports:   clk, rstnn (async active-low), clear (sync flush),
//          bus (slave modport: winst_info/in_valid/in_ready/in_row/in_txn_info,
//               out_valid/out_ready/out_wdata/out_wstrb/out_last/out_txn_info).
// Config:  DCA_STORE_SATURATE_EN (in dca_lsu_store_elem_narrow) enables integer saturation.
module dca_matrix_lsu_store_packer
    import dca_matrix_lsu_store_packer_pkg::*;
(
    input  logic                          clk,
    input  logic                          rstnn,
    input  logic                          clear,
    dca_matrix_lsu_store_packer_if.slave  bus
);

    localparam int CW = $clog2(MATRIX_NUM_COL);
    localparam int EW = $clog2(BW_LSU_ELEMENT);

    winst_info_t                     w_winst;
    logic [2:0]                      w_lsa;
    logic [BW_LSU_ELEMENT-1:0]       w_narrow [MATRIX_NUM_COL];
    logic [BW_MEMORY_ROW_BUFFER-1:0] w_wdata;
    logic [BW_MEMORY_ROW_BUFFER-1:0] w_ben;
    logic [BW_WSTRB-1:0]             w_wstrb;
    row_entry_t                      w_new;
    logic                            w_push;
    logic                            w_pop;

    row_entry_t r_q0;
    row_entry_t r_q1;
    logic [1:0] r_count;
    logic [7:0] r_row_cnt;

    assign w_winst = bus.winst_info;
    assign w_lsa   = clamp_lsa(w_winst.addr_lsa_p3);

    logic w_unused_winst;
    assign w_unused_winst = ^{w_winst.num_col_m1, w_winst.stride_ls3, w_winst.addr, w_winst.opcode};

    for (genvar g = 0; g < MATRIX_NUM_COL; g++) begin : g_narrow
        dca_lsu_store_elem_narrow u_narrow (
            .i_elem      (bus.in_row[g*BW_LSU_ELEMENT +: BW_LSU_ELEMENT]),
            .i_lsa       (w_lsa),
            .i_is_signed (w_winst.is_signed),
            .i_is_float  (w_winst.is_float),
            .o_elem      (w_narrow[g])
        );
    end

    // Each output bit k belongs to column k>>lsa at offset k mod W; w_ben marks bits
    // owned by enabled columns, which drives both data gating and the strobes.
    always_comb begin
        w_wdata = '0;
        w_ben   = '0;
        for (int k = 0; k < BW_MEMORY_ROW_BUFFER; k++) begin
            int col;
            int off;
            col = k >> w_lsa;
            off = k & ((1 << w_lsa) - 1);
            if (col < MATRIX_NUM_COL) begin
                w_ben[k]   = w_winst.col_mask[col[CW-1:0]];
                w_wdata[k] = w_ben[k] & w_narrow[col[CW-1:0]][off[EW-1:0]];
            end
        end
    end

    // A byte is strobed when any of its bits belongs to an enabled column, so sub-byte
    // masked neighbours are written as zero rather than preserved.
    always_comb begin
        w_wstrb = '0;
        for (int b = 0; b < BW_WSTRB; b++) begin
            w_wstrb[b] = |w_ben[8*b +: 8];
        end
    end

    assign w_new.wdata    = w_wdata;
    assign w_new.wstrb    = w_wstrb;
    assign w_new.last     = (r_row_cnt == w_winst.num_row_m1);
    assign w_new.txn_info = bus.in_txn_info;

    assign w_push = bus.in_valid & bus.in_ready;
    assign w_pop  = bus.out_valid & bus.out_ready;

    // r_q0 is always the head and feeds the outputs directly; r_q1 only holds the second row.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_q0      <= '0;
            r_q1      <= '0;
            r_count   <= 2'd0;
            r_row_cnt <= 8'd0;
        end else if (clear) begin
            r_count   <= 2'd0;
            r_row_cnt <= 8'd0;
        end else begin
            if (w_push) begin
                r_row_cnt <= w_new.last ? 8'd0 : r_row_cnt + 8'd1;
            end
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_q0    <= w_new;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_q0 <= w_new;
                    end else if (w_push) begin
                        r_q1    <= w_new;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_q0    <= r_q1;
                        r_count <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready     = (r_count != 2'd2);
    assign bus.out_valid    = (r_count != 2'd0);
    assign bus.out_wdata    = r_q0.wdata;
    assign bus.out_wstrb    = r_q0.wstrb;
    assign bus.out_last     = r_q0.last;
    assign bus.out_txn_info = r_q0.txn_info;

endmodule

// File: tb/tb_dca_matrix_lsu_store_packer.sv
// tb/tb_dca_matrix_lsu_store_packer.sv - self-checking bench for the store row packer
module tb_dca_matrix_lsu_store_packer;
    import dca_matrix_lsu_store_packer_pkg::*;

    logic clk = 1'b0;
    logic rstnn = 1'b0;
    logic clear = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dca_matrix_lsu_store_packer_if bus ();

    dca_matrix_lsu_store_packer dut (
        .clk   (clk),
        .rstnn (rstnn),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] wd;
        logic [15:0]  ws;
        logic         last;
        logic [7:0]   txn;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_row_cnt;

    function automatic winst_info_t mk_winst(input logic [3:0] mask, input logic [2:0] lsa,
                                             input logic flt, input logic sgn, input logic [7:0] nrm1);
        winst_info_t w;
        w.col_mask    = mask;
        w.addr_lsa_p3 = lsa;
        w.is_float    = flt;
        w.is_signed   = sgn;
        w.num_col_m1  = 8'd3;
        w.num_row_m1  = nrm1;
        w.stride_ls3  = 8'($urandom);
        w.addr        = $urandom;
        w.opcode      = 4'($urandom);
        return w;
    endfunction

    // Reference: each enabled column contributes its W-bit value at W*i and strobes
    // every byte from floor(W*i/8) through floor((W*i+W-1)/8).
    function automatic void ref_pack(input logic [127:0] row, input winst_info_t wi,
                                     output logic [127:0] wd, output logic [15:0] ws);
        int lsa;
        int w;
        longint unsigned fmask;
        lsa   = (wi.addr_lsa_p3 > 3'd5) ? 5 : int'(wi.addr_lsa_p3);
        w     = 1 << lsa;
        fmask = (64'd1 << w) - 64'd1;
        wd = '0;
        ws = '0;
        for (int i = 0; i < 4; i++) begin
            if (wi.col_mask[i]) begin
                longint v;
                longint unsigned f;
                logic [31:0] e;
                e = row[32*i +: 32];
                v = longint'($signed(e));
                f = longint'(e) & fmask;
`ifdef DCA_STORE_SATURATE_EN
                if (!wi.is_float) begin
                    if (wi.is_signed) begin
                        longint lo;
                        longint hi;
                        lo = -(longint'(1) << (w - 1));
                        hi = (longint'(1) << (w - 1)) - 1;
                        if (v > hi) v = hi;
                        if (v < lo) v = lo;
                        f = v & fmask;
                    end else begin
                        if (v < 0) f = 0;
                        else if (v > longint'(fmask)) f = fmask;
                        else f = v;
                    end
                end
`endif
                wd = wd | (128'(f) << (w * i));
                for (int b = (w * i) / 8; b <= (w * i + w - 1) / 8; b++) ws[b] = 1'b1;
            end
        end
    endfunction

    function automatic void ref_push(input winst_info_t wi, input logic [127:0] row, input logic [7:0] txn);
        exp_t e;
        ref_pack(row, wi, e.wd, e.ws);
        e.last = (m_row_cnt == wi.num_row_m1);
        e.txn  = txn;
        m_row_cnt = e.last ? 8'd0 : m_row_cnt + 8'd1;
        exp_q.push_back(e);
    endfunction

    function automatic logic [127:0] rand_row();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 0) r[32*i +: 32] = $urandom;
            else r[32*i +: 32] = 32'($urandom_range(0, 600)) - 32'd300;
        end
        return r;
    endfunction

    task automatic do_clear();
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_q.delete();
        m_row_cnt = 8'd0;
    endtask

    task automatic send_and_get(input winst_info_t wi, input logic [127:0] row, input logic [7:0] txn,
                                output logic [127:0] wd, output logic [15:0] ws, output logic lst,
                                output logic [7:0] tx, output bit ok);
        int n;
        ok = 1'b1;
        @(posedge clk); #1;
        bus.winst_info  = wi;
        bus.in_row      = row;
        bus.in_txn_info = txn;
        bus.in_valid    = 1'b1;
        bus.out_ready   = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.in_ready) ok = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
        if (!bus.out_valid) ok = 1'b0;
        wd  = bus.out_wdata;
        ws  = bus.out_wstrb;
        lst = bus.out_last;
        tx  = bus.out_txn_info;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic stream_rows(input int n, input logic [7:0] nrm1, output logic [7:0] lasts,
                               output int acc_cycles, output int got);
        int sent;
        sent = 0; got = 0; acc_cycles = 0; lasts = '0;
        @(posedge clk); #1;
        bus.out_ready   = 1'b1;
        bus.in_valid    = 1'b1;
        bus.winst_info  = mk_winst(4'hF, 3'd3, 1'b0, 1'b0, nrm1);
        bus.in_row      = rand_row();
        bus.in_txn_info = 8'(sent);
        for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin lasts[got] = bus.out_last; got++; end
            if (bus.in_valid) acc_cycles++;
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk); #1;
            bus.in_valid    = (sent < n);
            bus.in_txn_info = 8'(sent);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstnn = 1'b0;
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_wdata !== 128'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", bus.out_wdata); end
        checks++; if (bus.out_wstrb !== 16'd0) begin errors++; $display("FAIL reset_wstrb got %h want 0", bus.out_wstrb); end
        checks++; if (bus.out_last !== 1'b0 || bus.out_txn_info !== 8'd0) begin
            errors++; $display("FAIL reset_last_txn got %b/%h want 0/00", bus.out_last, bus.out_txn_info); end
        @(negedge clk); @(negedge clk);
        rstnn = 1'b1;
    endtask

    task automatic test_pack_vectors();
        logic [127:0] wd;
        logic [15:0]  ws;
        logic         lst;
        logic [7:0]   tx;
        bit           ok;
        logic [127:0] exp_wd;
        do_clear();
        // signed bytes: -1, 127, 128, 5
`ifdef DCA_STORE_SATURATE_EN
        exp_wd = 128'h057F7FFF;
`else
        exp_wd = 128'h05807FFF;
`endif
        send_and_get(mk_winst(4'hF, 3'd3, 1'b0, 1'b1, 8'd0), {32'd5, 32'd128, 32'd127, 32'hFFFFFFFF}, 8'h11, wd, ws, lst, tx, ok);
        checks++; if (!ok) begin errors++; $display("FAIL vec1_handshake timed out"); end
        checks++; if (wd !== exp_wd) begin errors++; $display("FAIL vec1_wdata got %h want %h", wd, exp_wd); end
        checks++; if (ws !== 16'h000F) begin errors++; $display("FAIL vec1_wstrb got %h want 000f", ws); end
        checks++; if (lst !== 1'b1 || tx !== 8'h11) begin errors++; $display("FAIL vec1_last_txn got %b/%h want 1/11", lst, tx); end
        // 2-bit fields, column 2 masked
        send_and_get(mk_winst(4'b1011, 3'd1, 1'b0, 1'b0, 8'd0), {32'd0, 32'd3, 32'd2, 32'd1}, 8'h22, wd, ws, lst, tx, ok);
        checks++; if (!ok) begin errors++; $display("FAIL vec2_handshake timed out"); end
        checks++; if (wd !== 128'h09 || ws !== 16'h0001) begin errors++; $display("FAIL vec2_pack got %h/%h want 09/0001", wd, ws); end
        // 32-bit fields at lsa=5 and lsa=7 (treated as 5)
        for (int j = 0; j < 2; j++) begin
            logic [2:0] lsa;
            lsa = (j == 0) ? 3'd5 : 3'd7;
`ifdef DCA_STORE_SATURATE_EN
            exp_wd = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
`else
            exp_wd = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
`endif
            send_and_get(mk_winst(4'hF, lsa, 1'b0, 1'b0, 8'd0), {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF}, 8'h33, wd, ws, lst, tx, ok);
            checks++; if (!ok) begin errors++; $display("FAIL vec3_handshake lsa=%0d timed out", lsa); end
            checks++; if (wd !== exp_wd || ws !== 16'hFFFF) begin
                errors++; $display("FAIL vec3_pack lsa=%0d got %h/%h want %h/ffff", lsa, wd, ws, exp_wd); end
        end
        // 16-bit float fields, columns 1 and 3 masked
        send_and_get(mk_winst(4'b0101, 3'd4, 1'b1, 1'b1, 8'd0), {32'h99999999, 32'h0000BEEF, 32'h77777777, 32'hAAAA1234}, 8'h44, wd, ws, lst, tx, ok);
        checks++; if (!ok) begin errors++; $display("FAIL vec4_handshake timed out"); end
        checks++; if (wd !== 128'h0000BEEF00001234 || ws !== 16'h0033) begin
            errors++; $display("FAIL vec4_pack got %h/%h want 0000beef00001234/0033", wd, ws); end
    endtask

    task automatic test_backpressure();
        winst_info_t  wi [3];
        logic [127:0] rw [3];
        int           got;
        int           sent;
        exp_t         e;
        do_clear();
        for (int k = 0; k < 3; k++) begin
            wi[k] = mk_winst(4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 8'd1);
            rw[k] = rand_row();
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            bus.winst_info = wi[k]; bus.in_row = rw[k]; bus.in_txn_info = 8'hA1 + 8'(k); bus.in_valid = 1'b1;
            @(negedge clk);
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept%0d in_ready got %b want 1", k, bus.in_ready); end
            ref_push(wi[k], rw[k], 8'hA1 + 8'(k));
        end
        @(posedge clk); #1;
        bus.winst_info = wi[2]; bus.in_row = rw[2]; bus.in_txn_info = 8'hA3;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full in_ready got %b want 0", bus.in_ready); end
        @(negedge clk); @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_txn_info !== 8'hA1 || bus.out_wdata !== exp_q[0].wd) begin
            errors++; $display("FAIL bp_hold got v=%b txn=%h wd=%h want v=1 txn=a1 wd=%h", bus.out_valid, bus.out_txn_info, bus.out_wdata, exp_q[0].wd); end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        got = 0; sent = 2;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            @(negedge clk);
            if (bus.out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.out_wdata !== e.wd || bus.out_wstrb !== e.ws || bus.out_last !== e.last || bus.out_txn_info !== e.txn) begin
                    errors++; $display("FAIL bp_drain%0d got %h/%h/%b/%h want %h/%h/%b/%h", got, bus.out_wdata, bus.out_wstrb,
                                       bus.out_last, bus.out_txn_info, e.wd, e.ws, e.last, e.txn); end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin ref_push(wi[2], rw[2], 8'hA3); sent++; end
            @(posedge clk); #1;
            if (sent == 3) bus.in_valid = 1'b0;
        end
        checks++; if (got !== 3) begin errors++; $display("FAIL bp_count got %0d want 3", got); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty out_valid got %b want 0", bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_last_and_clear();
        logic [7:0] lasts;
        int         acc;
        int         got;
        do_clear();
        stream_rows(4, 8'd2, lasts, acc, got);
        checks++; if (got !== 4 || lasts[3:0] !== 4'b0100) begin
            errors++; $display("FAIL last_seq got n=%0d flags=%b want n=4 flags=0100", got, lasts[3:0]); end
        checks++; if (acc !== 4) begin errors++; $display("FAIL back_to_back accept cycles got %0d want 4", acc); end
        do_clear();
        stream_rows(2, 8'd2, lasts, acc, got);
        checks++; if (got !== 2 || lasts[1:0] !== 2'b00) begin
            errors++; $display("FAIL last_pre_clear got n=%0d flags=%b want n=2 flags=00", got, lasts[1:0]); end
        do_clear();
        stream_rows(3, 8'd2, lasts, acc, got);
        checks++; if (got !== 3 || lasts[2:0] !== 3'b100) begin
            errors++; $display("FAIL last_post_clear got n=%0d flags=%b want n=3 flags=100", got, lasts[2:0]); end
    endtask

    task automatic test_async_reset();
        logic [7:0] lasts;
        int         acc;
        int         got;
        do_clear();
        stream_rows(1, 8'd3, lasts, acc, got);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            bus.winst_info = mk_winst(4'hF, 3'd3, 1'b0, 1'b0, 8'd3); bus.in_row = rand_row();
            bus.in_txn_info = 8'hC0 + 8'(k); bus.in_valid = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL arst_prefill got rdy=%b v=%b want 0/1", bus.in_ready, bus.out_valid); end
        @(posedge clk); #3;
        rstnn = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_wdata !== 128'd0) begin
            errors++; $display("FAIL arst_immediate got v=%b rdy=%b wd=%h want 0/1/0", bus.out_valid, bus.in_ready, bus.out_wdata); end
        @(negedge clk);
        rstnn = 1'b1;
        stream_rows(2, 8'd1, lasts, acc, got);
        checks++; if (got !== 2 || lasts[1:0] !== 2'b10) begin
            errors++; $display("FAIL arst_row_cnt got n=%0d flags=%b want n=2 flags=10", got, lasts[1:0]); end
    endtask

    task automatic test_random();
        winst_info_t  wi;
        logic [127:0] rw;
        logic [7:0]   tx;
        bit           accepted;
        exp_t         e;
        do_clear();
        wi = mk_winst(4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)));
        rw = rand_row(); tx = 8'($urandom);
        bus.winst_info = wi; bus.in_row = rw; bus.in_txn_info = tx;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== (exp_q.size() != 0) || bus.in_ready !== (exp_q.size() < 2)) begin
                errors++; $display("FAIL rnd_status cyc=%0d got v=%b rdy=%b want occupancy %0d", cyc, bus.out_valid, bus.in_ready, exp_q.size()); end
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.out_wdata !== e.wd || bus.out_wstrb !== e.ws || bus.out_last !== e.last || bus.out_txn_info !== e.txn) begin
                    errors++; $display("FAIL rnd_data cyc=%0d got %h/%h/%b/%h want %h/%h/%b/%h", cyc, bus.out_wdata, bus.out_wstrb,
                                       bus.out_last, bus.out_txn_info, e.wd, e.ws, e.last, e.txn); end
            end
            accepted = bus.in_valid && bus.in_ready;
            if (accepted) ref_push(wi, rw, tx);
            @(posedge clk); #1;
            if (accepted || !bus.in_valid) begin
                wi = mk_winst(4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)));
                rw = rand_row(); tx = 8'($urandom);
                bus.winst_info = wi; bus.in_row = rw; bus.in_txn_info = tx;
                bus.in_valid = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (bus.out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.out_wdata !== e.wd || bus.out_wstrb !== e.ws || bus.out_last !== e.last || bus.out_txn_info !== e.txn) begin
                    errors++; $display("FAIL rnd_drain got %h/%h/%b/%h want %h/%h/%b/%h", bus.out_wdata, bus.out_wstrb,
                                       bus.out_last, bus.out_txn_info, e.wd, e.ws, e.last, e.txn); end
            end
            @(posedge clk); #1;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_leftover got %0d rows pending want 0", exp_q.size()); end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.winst_info  = '0;
        bus.in_valid    = 1'b0;
        bus.in_row      = '0;
        bus.in_txn_info = '0;
        bus.out_ready   = 1'b0;
        m_row_cnt       = 8'd0;
        test_reset();
        test_pack_vectors();
        test_backpressure();
        test_last_and_clear();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
